reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor to the single-output power-on reset generator.
- Accepts an asynchronous active-low reset and a synchronous software reset request.
- Drives N_OUT active-high reset outputs, asserted asynchronously and released synchronously one after another in a staggered sequence after a programmable hold time.
- Sits at the top of the processor core and sequences reset release to the core, memories and peripherals; it also reports the cause of the last reset.

Parameters:
- N_OUT, 4: number of reset outputs (>=1).
- SYNC_STAGES, 2: depth of the deassertion synchroniser (>=2).
- HOLD_CYCLES, 16: cycles all outputs stay asserted after synchronised release or a software request (>=1).
- STAGGER_CYCLES, 4: cycles between release of consecutive outputs (0 = release all together).
- CNT_W, derived: clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1), counter width; not overridable.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised internally.
- sw_reset_req  in  1  synchronous software reset request, sampled on rising clk.
- rst_out  out  N_OUT  active-high resets; bit 0 is released first, bit N_OUT-1 last.
- ready  out  1  high when all rst_out bits are released.
- cause  out  2  last reset cause: 2'b01 external/POR, 2'b10 software; 2'b00 and 2'b11 are never driven.

Behaviour:
- Clock and reset scheme: one clock. reset_n is asynchronous and active-low.
- While reset_n=0 (asynchronous, no clock needed):
  - rst_out = all ones, ready=0, cause=2'b01.
  - state=SYNC, counter=0, synchroniser cleared.
- Synchroniser: a SYNC_STAGES-deep flop chain with data input 1, asynchronously cleared by reset_n. Its output rises at the SYNC_STAGES-th rising edge after reset_n deasserts.
- States: SYNC, HOLD, RELEASE, RUN.
  - SYNC: all outputs asserted. When the synchroniser output is 1, go to HOLD on that edge with counter=0.
  - HOLD: all outputs asserted; counter increments each edge. At the edge where counter==HOLD_CYCLES-1:
    - clear rst_out[0] and set idx=1;
    - if N_OUT==1, go to RUN and set ready at the same edge;
    - otherwise go to RELEASE with counter=0.
  - RELEASE: counter increments each edge. At the edge where counter==STAGGER_CYCLES-1:
    - clear rst_out[idx], idx++, counter=0;
    - after clearing bit N_OUT-1, go to RUN and set ready at the same edge.
    - STAGGER_CYCLES=0: all remaining bits clear at the same edge as bit 0, straight to RUN.
  - RUN: rst_out=0, ready=1. Hold until an event.
- Timing from reset_n rise (reset_n meets recovery before the first edge):
  - rst_out[i] falls at edge SYNC_STAGES+HOLD_CYCLES+i*STAGGER_CYCLES.
  - ready rises at the same edge as rst_out[N_OUT-1] falls.
- Software reset: sw_reset_req=1 sampled at edge e in HOLD, RELEASE or RUN:
  - at e: rst_out = all ones, ready=0, cause=2'b10, state=HOLD, counter=0;
  - rst_out[i] falls at edge e+HOLD_CYCLES+i*STAGGER_CYCLES.
  - Held high continuously: HOLD keeps restarting and outputs stay asserted.
  - Ignored in SYNC.
- Boundary conditions:
  - reset_n falling mid-HOLD/RELEASE/RUN: immediate asynchronous reassertion of all outputs, cause=2'b01, restart from SYNC.
  - reset_n glitch shorter than a clock: still fully resets; the sequence restarts.
  - Monotonic release: once released, a bit is reasserted only by reset_n or a software reset. rst_out[i] is never low while rst_out[j<i] is high.
  - rst_out and ready come directly from flops, so they are glitch-free.
  - Elaboration error if N_OUT<1, SYNC_STAGES<2 or HOLD_CYCLES<1.

Decomposition:
- Shared package reset_pkg:
  - state enum rst_state_t {SYNC, HOLD, RELEASE, RUN};
  - cause constants CAUSE_EXT=2'b01, CAUSE_SW=2'b10.
- One sub-module: reset_synchronizer (parameter STAGES; ports clk, reset_n, sync_out), an async-clear flop chain reusable elsewhere in the core.
- Counter, index and FSM live in reset_sequencer.

Test Plan:
All scenarios use defaults (N_OUT=4, SYNC_STAGES=2, HOLD_CYCLES=16, STAGGER_CYCLES=4) unless noted.
1. Power-up: reset_n low for 3 cycles, then high before edge 1 -> rst_out=4'b1111 throughout reset; bits 0..3 fall at edges 18/22/26/30; ready=1 at edge 30; cause=2'b01.
2. Software reset: in RUN, pulse sw_reset_req at edge e -> rst_out=4'b1111 and ready=0 at e; bits fall at e+16/e+20/e+24/e+28; cause=2'b10.
3. Software request mid-release: pulse sw_reset_req at edge 23 (rst_out=4'b1100) -> rst_out=4'b1111 at 23; bit0 falls at 39, ready at 51.
4. Async reset mid-operation: drive reset_n low between edges 25 and 26 -> rst_out=4'b1111 and ready=0 immediately, without a clock edge; cause=2'b01; after release the full 18/22/26/30 timeline repeats.
5. Parameter corners:
   - STAGGER_CYCLES=0 -> all bits fall together at edge 18.
   - N_OUT=1, HOLD_CYCLES=1 -> rst_out falls and ready rises at edge 3.
6. Continuous sw_reset_req for 40 cycles from RUN -> outputs stay 4'b1111 throughout; bit0 falls 16 edges after the last sampled request.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types and constants for the reset sequencing logic.
package reset_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_state_t;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Async-clear flop chain: output rises STAGES clocks after reset_n deasserts.
module reset_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Shift a constant one through the chain; any reset_n assertion clears it at once.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) chain <= '0;
    else          chain <= (chain << 1) | STAGES'(1);
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset release sequencer with software reset and reset-cause reporting.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int N_OUT          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_reset_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready,
  output logic [1:0]       cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] BIT0      = N_OUT'(1);
  // Releasing everything at once when there is one output or no stagger.
  localparam bit ALL_AT_ONCE = (N_OUT == 1) || (STAGGER_CYCLES == 0);
  // The state register's SYNC->HOLD step is the final synchroniser stage, so
  // HOLD is entered on the very edge the full SYNC_STAGES-deep chain would rise.
  localparam int PRE_STAGES = (SYNC_STAGES > 2) ? SYNC_STAGES - 1 : 1;

  if (N_OUT < 1) begin : g_bad_n_out
    $error("reset_sequencer: N_OUT must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end

  rst_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [N_OUT-1:0] rst_next;
  logic             ready_next;
  logic [1:0]       cause_next;
  logic             sync_rise;
  logic             sw_hit;
  logic             hold_done;
  logic             stag_done;
  logic             last_bit;

  reset_synchronizer #(
    .STAGES(PRE_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_out(sync_rise)
  );

  assign sw_hit    = sw_reset_req && (state != SYNC);
  assign hold_done = (state == HOLD) && (cnt == HOLD_LAST);
  assign stag_done = (state == RELEASE) && (cnt == STAG_LAST);
  assign last_bit  = (idx == IDX_LAST);

  // State register plus registered outputs, so rst_out/ready/cause never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SYNC;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_EXT;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      rst_out <= rst_next;
      ready   <= ready_next;
      cause   <= cause_next;
    end
  end

  // Next-state, counter and release-index logic; software request restarts HOLD.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    if (sw_hit) begin
      state_next = HOLD;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      unique case (state)
        SYNC: begin
          if (sync_rise) begin
            state_next = HOLD;
            cnt_next   = '0;
          end
        end
        HOLD: begin
          if (hold_done) begin
            cnt_next   = '0;
            idx_next   = IDX_W'(1);
            state_next = ALL_AT_ONCE ? RUN : RELEASE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (stag_done) begin
            cnt_next = '0;
            if (last_bit) state_next = RUN;
            else          idx_next   = idx + IDX_W'(1);
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        RUN: ;
        default: state_next = SYNC;
      endcase
    end
  end

  // Output values to be registered: clear one bit per release step, flag ready on the last.
  always_comb begin
    rst_next   = rst_out;
    ready_next = ready;
    cause_next = cause;
    if (sw_hit) begin
      rst_next   = '1;
      ready_next = 1'b0;
      cause_next = CAUSE_SW;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_done) begin
            if (ALL_AT_ONCE) begin
              rst_next   = '0;
              ready_next = 1'b1;
            end else begin
              rst_next = rst_out & ~BIT0;
            end
          end
        end
        RELEASE: begin
          if (stag_done) begin
            rst_next   = rst_out & ~(BIT0 << idx);
            ready_next = last_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised and directed bench for reset_sequencer; three parameterisations share stimulus.
module tb_reset_sequencer;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sw = 1'b0;

  logic [3:0] rst_a;  logic ready_a; logic [1:0] cause_a;
  logic [3:0] rst_b;  logic ready_b; logic [1:0] cause_b;
  logic [0:0] rst_c;  logic ready_c; logic [1:0] cause_c;

  reset_sequencer #(.N_OUT(4), .SYNC_STAGES(SS), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw), .rst_out(rst_a), .ready(ready_a), .cause(cause_a));
  reset_sequencer #(.N_OUT(4), .SYNC_STAGES(SS), .HOLD_CYCLES(16), .STAGGER_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw), .rst_out(rst_b), .ready(ready_b), .cause(cause_b));
  reset_sequencer #(.N_OUT(1), .SYNC_STAGES(SS), .HOLD_CYCLES(1), .STAGGER_CYCLES(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw), .rst_out(rst_c), .ready(ready_c), .cause(cause_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edge count, edge at which the hold window starts, and last cause.
  int         n = 0;
  int         start = 0;
  bit         valid = 1'b0;
  logic [1:0] exp_cause = 2'b01;

  // Bit i is held while fewer than hold + i*stag edges have passed since the hold start.
  function automatic logic [3:0] exp_rst(input int nb, input int hold, input int stag);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[i] = !valid || (n < start + hold + i * stag);
    return r;
  endfunction

  function automatic logic [3:0] exp_ready(input int nb, input int hold, input int stag);
    return {3'b000, valid && (n >= start + hold + (nb - 1) * stag)};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a.rst",   rst_a,             exp_rst(4, 16, 4));
    check("a.ready", {3'b000, ready_a}, exp_ready(4, 16, 4));
    check("a.cause", {2'b00, cause_a},  {2'b00, exp_cause});
    check("b.rst",   rst_b,             exp_rst(4, 16, 0));
    check("b.ready", {3'b000, ready_b}, exp_ready(4, 16, 0));
    check("b.cause", {2'b00, cause_b},  {2'b00, exp_cause});
    check("c.rst",   {3'b000, rst_c},   exp_rst(1, 1, 0));
    check("c.ready", {3'b000, ready_c}, exp_ready(1, 1, 0));
    check("c.cause", {2'b00, cause_c},  {2'b00, exp_cause});
  endtask

  // One clock edge: update the model with the sampled request, then check 1 ns later.
  task automatic step();
    @(posedge clk);
    n++;
    if (valid && reset_n && sw && n > start) begin
      start     = n;
      exp_cause = 2'b10;
    end
    #1;
    check_all();
  endtask

  // Called 1 ns after an edge: drop reset_n mid-cycle, check the asynchronous response,
  // keep it low across 'cycles' edges, then release before the next edge.
  task automatic pulse_reset(input int cycles);
    #3;
    reset_n   = 1'b0;
    valid     = 1'b0;
    exp_cause = 2'b01;
    #1;
    check_all();
    repeat (cycles) step();
    #1;
    reset_n = 1'b1;
    valid   = 1'b1;
    start   = n + SS;
  endtask

  initial begin
    // Power-up: reset asserted before any clock edge, held for 3 edges.
    #1 reset_n = 1'b0;
    #1 check_all();
    repeat (3) step();
    #1;
    reset_n = 1'b1;
    valid   = 1'b1;
    start   = n + SS;
    repeat (32) step();

    // Software reset pulse from RUN.
    sw = 1'b1; step(); sw = 1'b0;
    repeat (32) step();

    // Software reset mid-release (relative edge 23, outputs 1100 beforehand).
    pulse_reset(1);
    while (n < start + 20) step();
    sw = 1'b1; step(); sw = 1'b0;
    repeat (40) step();

    // Sub-cycle reset glitch between relative edges 25 and 26.
    pulse_reset(1);
    while (n < start + 23) step();
    pulse_reset(0);
    repeat (32) step();

    // Multi-cycle reset during HOLD.
    while (n < start + 10) step();
    pulse_reset(2);
    repeat (32) step();

    // Request held for 40 cycles from RUN.
    while (n < start + 30) step();
    sw = 1'b1;
    repeat (40) step();
    sw = 1'b0;
    repeat (32) step();

    // Random requests and occasional asynchronous resets.
    repeat (400) begin
      sw = ($urandom_range(0, 11) == 0);
      step();
      if ($urandom_range(0, 79) == 0) pulse_reset($urandom_range(0, 2));
    end
    sw = 1'b0;
    repeat (32) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
